ss_seq_ctrl: RTL and testbench
==============================

// Module: ss_seq_ctrl
// PURPOSE
//  Save-state sequencer for the mapper register file. It saves mapper registers into a state buffer and restores them from it.
//  It drives ss_act/ss_we/ss_addr into the mapper and moves data to/from the state buffer (BRAM).
//  Sits between the system save-state engine (start/done handshake) and map_* modules; only ss_* path touches mapper regs.
// PARAMETERS
//  REG_CNT   8    number of mapper regs saved/restored, ss_addr 0..REG_CNT-1 (1..127)
//  ID_ADDR   127  ss_addr returning map_idx; checked on load, never written
//  M2_TMO    255  clk cycles to wait for an m2 falling edge before err (8-bit max)
// PORTS
//  clk        in   1  system clock
//  rst        in   1  async active-high reset
//  m2         in   1  CPU M2, async; mapper regs latch on its negedge
//  save_req   in   1  pulse: start save
//  load_req   in   1  pulse: start load
//  busy       out  1  high from accepted req until done
//  done       out  1  1-cycle pulse at end of save/load (incl. error abort)
//  err        out  1  sticky until next accepted req: ID mismatch or m2 timeout
//  ss_act     out  1  to mapper: save-state access active
//  ss_we      out  1  to mapper: write strobe, held across one m2 negedge
//  ss_addr    out  8  to mapper: register index
//  ss_wdat    out  8  to mapper: write data (drives cpu_dat mux upstream)
//  ss_rdat    in   8  from mapper: combinational readback of ss_addr
//  buf_addr   out  8  state buffer address (== ss_addr slot)
//  buf_wdat   out  8  state buffer write data
//  buf_we     out  1  state buffer write strobe
//  buf_rdat   in   8  state buffer read data, 1-clk latency
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; ss_addr/buf_addr 0; m2 sync flops 0.
//  m2 via 2-flop sync; m2 fall = sync1 low & sync2 high (registered edge detect).
//  IDLE: save_req wins if both reqs are high in the same cycle. Reqs are ignored while busy. An accepted req clears err and sets busy.
//  SAVE: ss_act=1; per idx i in {0..REG_CNT-1, ID_ADDR}: cycle0 drive ss_addr=i; cycle1 buf_we=1, buf_addr=i, buf_wdat=ss_rdat.
//   Two clk per reg; total 2*(REG_CNT+1) clk, then done, busy=0, ss_act=0 next cycle.
//  LOAD: ss_act=1; first read buf[ID_ADDR] and compare to ss_rdat@ID_ADDR.
//   On mismatch: err=1, done, no ss_we ever asserted.
//   Else per i in 0..REG_CNT-1: RD (buf_addr=i) -> WAIT (1 clk latency) -> WR: ss_addr=i, ss_wdat=buf_rdat (registered), ss_we=1.
//   Hold WR until next m2 fall, then hold ss_we 1 more clk, drop ss_we, advance.
//  M2 timeout: counter reset on entering WR. If it reaches M2_TMO: err=1, ss_we=0, abort to DONE (remaining regs untouched).
//  ss_act stays high the whole op, so mapper CPU writes are blocked; it drops the cycle after done.
//  Index counter: 8 bit, no wrap; ID_ADDR slot handled by its own state, never by counter overflow.
//  rst mid-op: immediate return to IDLE and outputs 0; a partial restore is acceptable, upstream re-issues the request.
//  States: IDLE, S_ADDR, S_CAP, L_IDRD, L_IDCHK, L_RD, L_WAIT, L_WR, L_HOLD, [L_VRD, L_VCHK], DONE.
// CONFIGURATION
//  SS_VERIFY_EN defined: after each L_HOLD, L_VRD drives ss_addr=i and L_VCHK compares ss_rdat to the written value.
//   On mismatch, err=1 and load continues (all regs still written). This costs +2 clk per reg.
//  SS_VERIFY_EN undefined: no verify states; err only from ID mismatch/timeout.
// STRUCTURE
//  Shared pkg/defs (`include in ../base/defs.v): state encoding localparams, SS_ID_ADDR, buffer width defines.
//  One sub-module: m2_edge_det (2-flop sync + fall pulse, async rst); FSM + counters in ss_seq_ctrl.
// TESTING
//  Bench model: a map_232-style reg file (4-bit prg_bank @0, map_idx=232 @127) clocked on negedge m2, m2 = clk/6.
//  1 Save: REG_CNT=1, prg_bank=4'hA, save_req -> buf[0]=8'h0A, buf[127]=8'hE8; done after 4 clk; err=0.
//  2 Load: buf[0]=8'h05, buf[127]=8'hE8, load_req -> prg_bank=5 after one m2 fall; ss_we high across exactly one negedge.
//  3 ID mismatch: buf[127]=8'h07, load_req -> err=1, done pulse, ss_we never 1, prg_bank unchanged.
//  4 m2 stuck low (M2_TMO=16), load_req -> err=1 within 16 clk of L_WR entry, ss_we=0, busy=0 after done.
//  5 save_req & load_req same cycle, then load_req mid-op -> only the save runs; the second req is ignored; one done.
//  6 rst asserted in L_WR -> ss_act/ss_we/busy 0 asynchronously; next save_req completes normally; with SS_VERIFY_EN, a corrupted readback sets err.

Source files
------------

// File: rtl/ss_seq_ctrl_pkg.sv
// Shared definitions for the save-state sequencer: default sizing and FSM state encoding.
package ss_seq_ctrl_pkg;

  localparam int SS_REG_CNT = 8;
  localparam int SS_ID_ADDR = 127;
  localparam int SS_M2_TMO  = 255;

  typedef enum logic [3:0] {
    IDLE,
    S_ADDR,
    S_CAP,
    L_IDRD,
    L_IDCHK,
    L_RD,
    L_WAIT,
    L_WR,
    L_HOLD,
    L_VRD,
    L_VCHK,
    DONE
  } state_t;

endpackage

// File: rtl/ss_seq_ctrl_m2_edge_det.sv
// Synchronises the asynchronous CPU M2 into clk and flags its falling edge for one cycle.
module ss_seq_ctrl_m2_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic m2,
  output logic fall
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= m2;
      sync2 <= sync1;
    end
  end

  assign fall = ~sync1 & sync2;

endmodule

// File: rtl/ss_seq_ctrl.sv
// Save-state sequencer: copies mapper registers to/from the state buffer over the ss_* port.
// Define SS_VERIFY_EN to read back and compare every restored register.
module ss_seq_ctrl
  import ss_seq_ctrl_pkg::*;
#(
  parameter int REG_CNT = SS_REG_CNT,
  parameter int ID_ADDR = SS_ID_ADDR,
  parameter int M2_TMO  = SS_M2_TMO
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       m2,
  input  logic       save_req,
  input  logic       load_req,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] buf_addr,
  output logic [7:0] buf_wdat,
  output logic       buf_we,
  input  logic [7:0] buf_rdat
);

  localparam logic [7:0] LAST_IDX = 8'(REG_CNT - 1);
  localparam logic [7:0] ID       = 8'(ID_ADDR);
  localparam logic [7:0] TMO_LAST = 8'(M2_TMO - 1);

  state_t     state;
  logic [7:0] idx;
  logic [7:0] tmo;
  logic       m2_fall;

  ss_seq_ctrl_m2_edge_det m2_edge_det (
    .clk  (clk),
    .rst  (rst),
    .m2   (m2),
    .fall (m2_fall)
  );

  // NOTE: all state and outputs use non-blocking assignments so every branch
  // reads the pre-edge values; blocking here would create order-dependent logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      tmo      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      ss_act   <= 1'b0;
      ss_we    <= 1'b0;
      ss_addr  <= '0;
      ss_wdat  <= '0;
      buf_addr <= '0;
      buf_wdat <= '0;
      buf_we   <= 1'b0;
    end else begin
      done   <= 1'b0;
      buf_we <= 1'b0;
      case (state)
        IDLE: begin
          if (save_req) begin
            busy    <= 1'b1;
            err     <= 1'b0;
            ss_act  <= 1'b1;
            idx     <= '0;
            ss_addr <= '0;
            state   <= S_ADDR;
          end else if (load_req) begin
            busy     <= 1'b1;
            err      <= 1'b0;
            ss_act   <= 1'b1;
            ss_addr  <= ID;
            buf_addr <= ID;
            state    <= L_IDRD;
          end
        end
        S_ADDR: begin
          buf_we   <= 1'b1;
          buf_addr <= ss_addr;
          buf_wdat <= ss_rdat;
          state    <= S_CAP;
        end
        S_CAP: begin
          if (ss_addr == ID) begin
            done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else if (idx == LAST_IDX) begin
            ss_addr <= ID;
            state   <= S_ADDR;
          end else begin
            idx     <= idx + 8'd1;
            ss_addr <= idx + 8'd1;
            state   <= S_ADDR;
          end
        end
        L_IDRD: state <= L_IDCHK;
        L_IDCHK: begin
          if (buf_rdat != ss_rdat) begin
            err <= 1'b1;
            done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else begin
            idx      <= '0;
            buf_addr <= '0;
            state    <= L_RD;
          end
        end
        L_RD: state <= L_WAIT;
        L_WAIT: begin
          ss_addr <= idx;
          ss_wdat <= buf_rdat;
          ss_we   <= 1'b1;
          tmo     <= '0;
          state   <= L_WR;
        end
        L_WR: begin
          // A fall seen in the first WR cycle happened before ss_we rose, so it cannot count.
          if (m2_fall && tmo != 8'd0) begin
            state <= L_HOLD;
          end else if (tmo == TMO_LAST) begin
            err   <= 1'b1;
            ss_we <= 1'b0;
            done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else begin
            tmo <= tmo + 8'd1;
          end
        end
`ifdef SS_VERIFY_EN
        L_HOLD: begin
          ss_we <= 1'b0;
          state <= L_VRD;
        end
        L_VRD: state <= L_VCHK;
        L_VCHK: begin
          if (ss_rdat != ss_wdat) err <= 1'b1;
          if (idx == LAST_IDX) begin
            done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else begin
            idx      <= idx + 8'd1;
            buf_addr <= idx + 8'd1;
            state    <= L_RD;
          end
        end
`else
        L_HOLD: begin
          ss_we <= 1'b0;
          if (idx == LAST_IDX) begin
            done <= 1'b1; busy <= 1'b0; state <= DONE;
          end else begin
            idx      <= idx + 8'd1;
            buf_addr <= idx + 8'd1;
            state    <= L_RD;
          end
        end
`endif
        DONE: begin
          ss_act <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ss_seq_ctrl.sv
// Self-checking bench for ss_seq_ctrl against a map_232-style register file and a 1-clk BRAM model.
module tb_ss_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       m2 = 1'b0;
  logic       save_req, load_req;
  logic       busy, done, err, ss_act, ss_we, buf_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, buf_addr, buf_wdat, buf_rdat;

  logic [7:0] mem [0:255];
  logic [3:0] prg_bank;
  logic       corrupt;
  logic       m2_stuck = 1'b0;
  int         m2_cnt = 0;
  int         we_negs = 0;
  int         we_cycles = 0;
  int         total = 0;
  int         bad = 0;

  logic [15:0] exp_buf [$];
  logic        exp_done [$];

  ss_seq_ctrl #(.REG_CNT(1), .ID_ADDR(127), .M2_TMO(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .m2       (m2),
    .save_req (save_req),
    .load_req (load_req),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ss_act   (ss_act),
    .ss_we    (ss_we),
    .ss_addr  (ss_addr),
    .ss_wdat  (ss_wdat),
    .ss_rdat  (ss_rdat),
    .buf_addr (buf_addr),
    .buf_wdat (buf_wdat),
    .buf_we   (buf_we),
    .buf_rdat (buf_rdat)
  );

  always #5 clk = ~clk;

  // m2 = clk/6, changing on clk falling edges so it never races ss_* updates
  always @(negedge clk) begin
    if (m2_stuck) m2 = 1'b0;
    else if (m2_cnt == 2) begin m2_cnt = 0; m2 = ~m2; end
    else m2_cnt++;
  end

  always_comb begin
    ss_rdat = 8'h00;
    if (ss_addr == 8'd0) ss_rdat = {4'h0, prg_bank} ^ (corrupt ? 8'h10 : 8'h00);
    else if (ss_addr == 8'd127) ss_rdat = 8'hE8;
  end

  always @(negedge m2) begin
    if (ss_act && ss_we) begin
      we_negs++;
      if (ss_addr == 8'd0) prg_bank = ss_wdat[3:0];
    end
  end

  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdat;
    buf_rdat <= mem[buf_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: buffer writes and done pulses are popped as the DUT produces them
  always @(negedge clk) begin
    logic [15:0] eb;
    logic        ed;
    if (ss_we === 1'b1) we_cycles++;
    if (buf_we === 1'b1) begin
      check("buf_sb_nonempty", 32'(exp_buf.size() != 0), 32'd1);
      if (exp_buf.size() != 0) begin
        eb = exp_buf.pop_front();
        check("buf_write", {16'h0, buf_addr, buf_wdat}, {16'h0, eb});
      end
    end
    if (done === 1'b1) begin
      check("done_sb_nonempty", 32'(exp_done.size() != 0), 32'd1);
      if (exp_done.size() != 0) begin
        ed = exp_done.pop_front();
        check("err_at_done", 32'(err), 32'(ed));
      end
    end
  end

  task automatic pulse(input logic s, input logic l);
    @(negedge clk); save_req = s; load_req = l;
    @(negedge clk); save_req = 1'b0; load_req = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_we(input int budget, input string tag);
    int n = 0;
    while (ss_we !== 1'b1 && n < budget) begin @(negedge clk); n++; end
    check(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int k;
    rst = 1'b1; save_req = 1'b0; load_req = 1'b0; prg_bank = 4'h0; corrupt = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ctl", {26'h0, busy, done, err, ss_act, ss_we, buf_we}, 32'h0);
    check("rst_addr", {16'h0, ss_addr, buf_addr}, 32'h0);
    check("rst_dat", {16'h0, ss_wdat, buf_wdat}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ctl", {26'h0, busy, done, err, ss_act, ss_we, buf_we}, 32'h0);

    // 1: save with prg_bank=A
    prg_bank = 4'hA;
    exp_buf.push_back({8'd0, 8'h0A});
    exp_buf.push_back({8'd127, 8'hE8});
    exp_done.push_back(1'b0);
    pulse(1'b1, 1'b0);
    check("save_busy", {30'h0, busy, ss_act}, 32'h3);
    repeat (3) @(negedge clk);
    check("save_done_early", 32'(done), 32'd0);
    @(negedge clk);
    check("save_done_4clk", {29'h0, done, busy, ss_act}, 32'h5);
    @(negedge clk);
    check("save_act_drop", {30'h0, done, ss_act}, 32'h0);
    check("save_buf0", 32'(mem[0]), 32'h0A);
    check("save_buf127", 32'(mem[127]), 32'hE8);

    // 2: load prg_bank=5
    mem[0] = 8'h05; mem[127] = 8'hE8;
    we_negs = 0;
    exp_done.push_back(1'b0);
    pulse(1'b0, 1'b1);
    wait_done(60, "load_to");
    check("load_prg", 32'(prg_bank), 32'h5);
    check("load_we_negs", 32'(we_negs), 32'd1);
    check("load_we_low", 32'(ss_we), 32'd0);
    @(negedge clk);
    check("load_act_drop", 32'(ss_act), 32'd0);

    // 3: ID mismatch
    mem[127] = 8'h07;
    we_cycles = 0;
    exp_done.push_back(1'b1);
    pulse(1'b0, 1'b1);
    wait_done(30, "idmis_to");
    @(negedge clk);
    check("idmis_err", 32'(err), 32'd1);
    check("idmis_we_cycles", 32'(we_cycles), 32'd0);
    check("idmis_prg", 32'(prg_bank), 32'h5);

    // 4: m2 stuck low
    mem[127] = 8'hE8; mem[0] = 8'h03;
    m2_stuck = 1'b1;
    exp_done.push_back(1'b1);
    pulse(1'b0, 1'b1);
    check("tmo_err_clr", 32'(err), 32'd0);
    wait_we(20, "tmo_we_to");
    k = 0;
    while (err !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("tmo_latency", 32'(k <= 16), 32'd1);
    check("tmo_we_off", {30'h0, ss_we, busy}, 32'h0);
    @(negedge clk);
    check("tmo_act_drop", {30'h0, busy, ss_act}, 32'h0);
    check("tmo_prg", 32'(prg_bank), 32'h5);
    m2_stuck = 1'b0;

    // 5: simultaneous reqs then a mid-op load_req
    we_cycles = 0;
    exp_buf.push_back({8'd0, 8'h05});
    exp_buf.push_back({8'd127, 8'hE8});
    exp_done.push_back(1'b0);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    pulse(1'b0, 1'b1);
    wait_done(20, "both_to");
    repeat (12) @(negedge clk);
    check("both_idle", {30'h0, busy, ss_act}, 32'h0);
    check("both_we_cycles", 32'(we_cycles), 32'd0);

    // 6: reset while in L_WR, then a clean save
    mem[0] = 8'h09; mem[127] = 8'hE8;
    pulse(1'b0, 1'b1);
    wait_we(40, "rst_we_to");
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("rst_async", {29'h0, ss_act, ss_we, busy}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    exp_buf.push_back({8'd0, 4'h0, prg_bank});
    exp_buf.push_back({8'd127, 8'hE8});
    exp_done.push_back(1'b0);
    pulse(1'b1, 1'b0);
    wait_done(20, "post_rst_to");
`ifdef SS_VERIFY_EN
    repeat (2) @(negedge clk);
    mem[0] = 8'h06; mem[127] = 8'hE8;
    corrupt = 1'b1;
    exp_done.push_back(1'b1);
    pulse(1'b0, 1'b1);
    wait_done(60, "verify_to");
    corrupt = 1'b0;
    check("verify_prg", 32'(prg_bank), 32'h6);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(exp_buf.size() + exp_done.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
